// File: rtl/shared_enc_ctrl_pkg.sv
// Shared definitions for the 2-share encryption sequencer: FSM states,
// default geometry and the round-counter width handed to the core.
package shared_enc_ctrl_pkg;

    localparam int unsigned NR_DEFAULT        = 16;
    localparam int unsigned ROUND_LAT_DEFAULT = 2;
    localparam int unsigned W_DEFAULT         = 128;

    // Round index bus to the core; wide enough for NR <= 31.
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Width of the per-round latency counter; never collapses to zero bits.
    function automatic int unsigned lat_width(input int unsigned lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/shared_enc_ctrl_if.sv
// Block-level stream port of the sequencer: plaintext share pair in,
// ciphertext share pair out, each with its own valid/ready handshake.
interface shared_enc_ctrl_if
    import shared_enc_ctrl_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] plain_in0;
    logic [W-1:0] plain_in1;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] cipher_out0;
    logic [W-1:0] cipher_out1;

    // Producer/consumer side of the block.
    modport master (
        output in_valid,
        output plain_in0,
        output plain_in1,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  cipher_out0,
        input  cipher_out1
    );

    // Sequencer side.
    modport slave (
        input  in_valid,
        input  plain_in0,
        input  plain_in1,
        input  out_ready,
        output in_ready,
        output out_valid,
        output cipher_out0,
        output cipher_out1
    );

endinterface

// File: rtl/shared_enc_ctrl.sv
// Sequencer upstream of the 2-share encryption core. Accepts a plaintext
// share pair, runs NR rounds of ROUND_LAT cycles each while stepping the
// share-wise key schedule, then presents the ciphertext share pair.
// Share 0 and share 1 are kept in separate registers and never combined.
module shared_enc_ctrl
    import shared_enc_ctrl_pkg::*;
#(
    parameter int unsigned NR        = NR_DEFAULT,
    parameter int unsigned ROUND_LAT = ROUND_LAT_DEFAULT,
    parameter int unsigned W         = W_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,          // active-high asynchronous reset
    shared_enc_ctrl_if.slave bus,
    output logic             ks_load,
    output logic             ks_next,
    output logic             enc_ena,
    output logic [CNT_W-1:0] enc_round_cnt,
    output logic [W-1:0]     plain0,
    output logic [W-1:0]     plain1,
    input  logic [W-1:0]     cipher0,
    input  logic [W-1:0]     cipher1,
    output logic             busy
);

    localparam int unsigned      LW        = lat_width(ROUND_LAT);
    localparam logic [LW-1:0]    LAT_LAST  = LW'(ROUND_LAT - 1);
    localparam logic [CNT_W-1:0] RND_LAST  = CNT_W'(NR - 1);
    localparam logic [CNT_W-1:0] RND_FINAL = CNT_W'(NR);
    localparam logic             LAT_ONE   = (ROUND_LAT == 1);

    state_t           state;
    logic [CNT_W-1:0] rnd;
    logic [LW-1:0]    lat;
    logic             accept;

    // in_ready is only ever high in IDLE, so this is the IDLE handshake.
    assign accept        = bus.in_valid && bus.in_ready;
    assign ks_load       = accept;
    assign enc_round_cnt = rnd;

    // Sequencer FSM with round/latency counters and share registers.
    // enc_ena, ks_next, busy and in_ready are registered from the next-state
    // decision so each one is valid during the cycle it describes.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state           <= ST_IDLE;
            rnd             <= '0;
            lat             <= '0;
            bus.in_ready    <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.cipher_out0 <= '0;
            bus.cipher_out1 <= '0;
            plain0          <= '0;
            plain1          <= '0;
            ks_next         <= 1'b0;
            enc_ena         <= 1'b0;
            busy            <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus.in_ready <= 1'b1;
                    if (accept) begin
                        plain0       <= bus.plain_in0;
                        plain1       <= bus.plain_in1;
                        rnd          <= '0;
                        lat          <= '0;
                        state        <= ST_RUN;
                        bus.in_ready <= 1'b0;
                        enc_ena      <= 1'b1;
                        busy         <= 1'b1;
                        // With a single-cycle round the first cycle is already the last.
                        ks_next      <= LAT_ONE;
                    end
                end

                ST_RUN: begin
                    if (lat == LAT_LAST) begin
                        lat <= '0;
                        if (rnd == RND_LAST) begin
                            rnd     <= RND_FINAL;
                            state   <= ST_FINAL;
                            enc_ena <= 1'b0;
                            ks_next <= 1'b0;
                        end else begin
                            rnd     <= rnd + 1'b1;
                            ks_next <= LAT_ONE;
                        end
                    end else begin
                        lat     <= lat + 1'b1;
                        ks_next <= ((lat + 1'b1) == LAT_LAST);
                    end
                end

                ST_FINAL: begin
                    // Core now shows the round NR-1 result XOR rk[NR].
                    bus.cipher_out0 <= cipher0;
                    bus.cipher_out1 <= cipher1;
                    bus.out_valid   <= 1'b1;
                    state           <= ST_DONE;
                end

                ST_DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        busy          <= 1'b0;
                        rnd           <= '0;
                        state         <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // in_ready must never be seen outside IDLE.
    ap_ready_only_idle: assert property (@(posedge clk) disable iff (rstn)
        bus.in_ready |-> (state == ST_IDLE));

    // Round counter saturates at NR.
    ap_rnd_range: assert property (@(posedge clk) disable iff (rstn)
        rnd <= RND_FINAL);

    // Key schedule never sees load and advance together.
    ap_ks_exclusive: assert property (@(posedge clk) disable iff (rstn)
        !(ks_load && ks_next));

    // Ciphertext holds while the consumer stalls.
    ap_out_hold: assert property (@(posedge clk) disable iff (rstn)
        (bus.out_valid && !bus.out_ready) |=>
            (bus.out_valid && $stable(bus.cipher_out0) && $stable(bus.cipher_out1)));

endmodule
